bram_port_arbiter: RTL and testbench

Shares the single user port (port A) of the 512×32 block RAM among three requesters: the serial-to-BRAM writer, the BRAM-to-serial reader and the perceptron controller's weight fetch. It replaces the ad-hoc address/enable muxing in front of the RAM with a registered, grant-based scheduler. The block guarantees that each access reaches the RAM exactly once and that read data is returned only to the requester that issued the read. It sits between those three engines and the RAM's port A, all on the 96 MHz domain.

---
 rtl/bram_arb_pkg.sv | 27 ++
 rtl/bram_arb_select.sv | 48 ++++
 rtl/bram_port_arbiter.sv | 133 +++++++++++++
 tb/tb_bram_port_arbiter.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/bram_arb_pkg.sv
// Shared constants, types and helpers for the block-RAM port-A arbiter.
// Consumers: bram_arb_select and bram_port_arbiter (optional BRAM_ARB_RR_EN).
package bram_arb_pkg;

   localparam int REQ_WR  = 0;
   localparam int REQ_TX  = 1;
   localparam int REQ_PC  = 2;
   localparam int NUM_REQ = 3;

   localparam int BRAM_ADDR_W = 9;
   localparam int BRAM_DATA_W = 32;

   typedef logic [NUM_REQ-1:0] gnt_vec_t;

   // Encode a one-hot grant into its requester index; an idle vector maps to 0.
   function automatic logic [1:0] onehot_to_idx(input gnt_vec_t v);
      logic [1:0] idx;
      case (v)
         3'b001:  idx = 2'd0;
         3'b010:  idx = 2'd1;
         3'b100:  idx = 2'd2;
         default: idx = 2'd0;
      endcase
      return idx;
   endfunction

endpackage

// File: rtl/bram_arb_select.sv
// Combinational 3-way requester picker producing a one-hot select.
// BRAM_ARB_RR_EN defined: round-robin after last_gnt; otherwise fixed wr > tx > pc.
module bram_arb_select
   import bram_arb_pkg::*;
(
`ifdef BRAM_ARB_RR_EN
   input  logic [1:0] last_gnt,
`endif
   input  gnt_vec_t   req_masked,
   output gnt_vec_t   sel
);

`ifdef BRAM_ARB_RR_EN
   logic found_s;
   int   idx_s;

   // Rotating search that starts at the requester after the last one served.
   always_comb begin
      sel     = '0;
      found_s = 1'b0;
      idx_s   = 0;
      for (int k = 1; k <= NUM_REQ; k++) begin
         idx_s = (int'(last_gnt) + k) % NUM_REQ;
         if (!found_s && req_masked[idx_s]) begin
            sel[idx_s] = 1'b1;
            found_s    = 1'b1;
         end else begin
            found_s = found_s;
         end
      end
   end
`else
   // Static priority: the writer always wins, the perceptron only when alone.
   always_comb begin
      sel = '0;
      if (req_masked[REQ_WR]) begin
         sel[REQ_WR] = 1'b1;
      end else if (req_masked[REQ_TX]) begin
         sel[REQ_TX] = 1'b1;
      end else if (req_masked[REQ_PC]) begin
         sel[REQ_PC] = 1'b1;
      end else begin
         sel = '0;
      end
   end
`endif

endmodule

// File: rtl/bram_port_arbiter.sv
// Registered grant scheduler sharing BRAM port A between writer, UART reader and perceptron.
// Optional round-robin selection is enabled by defining BRAM_ARB_RR_EN.
module bram_port_arbiter
   import bram_arb_pkg::*;
#(
   parameter  int ADDR_W = BRAM_ADDR_W,
   parameter  int DATA_W = BRAM_DATA_W,
   localparam int BE_W   = DATA_W / 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              wr_req,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [DATA_W-1:0] wr_data,
   input  logic [BE_W-1:0]   wr_be,
   output logic              wr_gnt,
   input  logic              tx_req,
   input  logic [ADDR_W-1:0] tx_addr,
   output logic              tx_gnt,
   output logic              tx_rvalid,
   input  logic              pc_req,
   input  logic [ADDR_W-1:0] pc_addr,
   output logic              pc_gnt,
   output logic              pc_rvalid,
   output logic              bram_en,
   output logic [BE_W-1:0]   bram_we,
   output logic [ADDR_W-1:0] bram_addr,
   output logic [DATA_W-1:0] bram_din,
   input  logic [DATA_W-1:0] bram_dout,
   output logic              busy
);

   gnt_vec_t          req_s;
   gnt_vec_t          req_masked_s;
   gnt_vec_t          sel_s;
   gnt_vec_t          gnt_r;
   logic [1:0]        rv_r;
   logic              en_r;
   logic [BE_W-1:0]   we_r;
   logic [ADDR_W-1:0] addr_r;
   logic [DATA_W-1:0] din_r;
   logic              nxt_en_s;
   logic [BE_W-1:0]   nxt_we_s;
   logic [ADDR_W-1:0] nxt_addr_s;
   logic [DATA_W-1:0] nxt_din_s;

   // A requester holding req during its grant cycle is hidden so it cannot win twice.
   assign req_s        = {pc_req, tx_req, wr_req};
   assign req_masked_s = req_s & ~gnt_r;

`ifdef BRAM_ARB_RR_EN
   logic [1:0] last_r;

   bram_arb_select u_select (
      .last_gnt   (last_r),
      .req_masked (req_masked_s),
      .sel        (sel_s)
   );

   // Remember the last served requester; reset points at pc so wr is searched first.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         last_r <= 2'(REQ_PC);
      end else if (|sel_s) begin
         last_r <= onehot_to_idx(sel_s);
      end else begin
         last_r <= last_r;
      end
   end
`else
   bram_arb_select u_select (
      .req_masked (req_masked_s),
      .sel        (sel_s)
   );
`endif

   // Port-A command for the next cycle; address and data hold when idle.
   always_comb begin
      nxt_en_s   = |sel_s;
      nxt_we_s   = '0;
      nxt_addr_s = addr_r;
      nxt_din_s  = din_r;
      case (sel_s)
         3'b001: begin
            nxt_addr_s = wr_addr;
            nxt_we_s   = wr_be;
            nxt_din_s  = wr_data;
         end
         3'b010: begin
            nxt_addr_s = tx_addr;
            nxt_din_s  = '0;
         end
         3'b100: begin
            nxt_addr_s = pc_addr;
            nxt_din_s  = '0;
         end
         default: begin
            nxt_din_s = din_r;
         end
      endcase
   end

   // Grant, port-A command and read-return pipe registers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         gnt_r  <= '0;
         en_r   <= 1'b0;
         we_r   <= '0;
         addr_r <= '0;
         din_r  <= '0;
         rv_r   <= 2'b00;
      end else begin
         gnt_r  <= sel_s;
         en_r   <= nxt_en_s;
         we_r   <= nxt_we_s;
         addr_r <= nxt_addr_s;
         din_r  <= nxt_din_s;
         rv_r   <= {gnt_r[REQ_PC], gnt_r[REQ_TX]};
      end
   end

   assign wr_gnt    = gnt_r[REQ_WR];
   assign tx_gnt    = gnt_r[REQ_TX];
   assign pc_gnt    = gnt_r[REQ_PC];
   assign tx_rvalid = rv_r[0];
   assign pc_rvalid = rv_r[1];
   assign bram_en   = en_r;
   assign bram_we   = we_r;
   assign bram_addr = addr_r;
   assign bram_din  = din_r;
   assign busy      = (|req_masked_s) | en_r | (|rv_r);

endmodule

// File: tb/tb_bram_port_arbiter.sv
// Randomized self-checking bench for bram_port_arbiter with a behavioural BRAM and arbitration model.
// Expectations follow BRAM_ARB_RR_EN when it is defined for the build.
module tb_bram_port_arbiter;

   logic        clk;
   logic        rst;
   logic        wr_req, tx_req, pc_req;
   logic [8:0]  wr_addr, tx_addr, pc_addr;
   logic [31:0] wr_data;
   logic [3:0]  wr_be;
   logic        wr_gnt, tx_gnt, pc_gnt, tx_rvalid, pc_rvalid;
   logic        bram_en, busy;
   logic [3:0]  bram_we;
   logic [8:0]  bram_addr;
   logic [31:0] bram_din, bram_dout;

   int checks = 0;
   int errors = 0;

   logic [31:0] ram    [512];
   logic [31:0] shadow [512];

   // Model state: what the outputs must show in the current cycle.
   logic [2:0]  m_gnt;
   logic        m_en;
   logic [3:0]  m_we;
   logic [8:0]  m_addr;
   logic [31:0] m_din;
   logic [1:0]  m_rv;
   int          m_last;
   logic [31:0] m_rd_val;
   logic [31:0] m_rv_val;

   bram_port_arbiter dut (
      .clk(clk), .rst(rst),
      .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_be(wr_be), .wr_gnt(wr_gnt),
      .tx_req(tx_req), .tx_addr(tx_addr), .tx_gnt(tx_gnt), .tx_rvalid(tx_rvalid),
      .pc_req(pc_req), .pc_addr(pc_addr), .pc_gnt(pc_gnt), .pc_rvalid(pc_rvalid),
      .bram_en(bram_en), .bram_we(bram_we), .bram_addr(bram_addr), .bram_din(bram_din),
      .bram_dout(bram_dout), .busy(busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Synchronous read-first block RAM with byte enables.
   always @(posedge clk) begin
      if (bram_en) begin
         for (int b = 0; b < 4; b++) begin
            if (bram_we[b]) ram[bram_addr][b*8 +: 8] <= bram_din[b*8 +: 8];
         end
         bram_dout <= ram[bram_addr];
      end
   end

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s observed=%h expected=%h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_gnt = 3'b000; m_en = 1'b0; m_we = 4'h0; m_addr = 9'h000;
      m_din = 32'h0; m_rv = 2'b00; m_last = 2; m_rd_val = 32'h0; m_rv_val = 32'h0;
   endtask

   // One clock: predict from the spec rules, advance, compare every output.
   task automatic step();
      logic [2:0] q, r;
      int idx;
      #1;
      q = {pc_req, tx_req, wr_req};
      r = q & ~m_gnt;
      check_eq("busy", {31'h0, busy}, {31'h0, (|r) | m_en | (|m_rv)});
      idx = -1;
`ifdef BRAM_ARB_RR_EN
      for (int k = 1; k <= 3; k++) if (idx < 0 && r[(m_last + k) % 3]) idx = (m_last + k) % 3;
`else
      for (int c = 0; c < 3; c++) if (idx < 0 && r[c]) idx = c;
`endif
      m_rv     = {m_gnt[2], m_gnt[1]};
      m_rv_val = m_rd_val;
      m_gnt    = 3'b000;
      m_en     = 1'b0;
      m_we     = 4'h0;
      if (idx >= 0) begin
         m_gnt[idx] = 1'b1;
         m_en       = 1'b1;
         m_last     = idx;
         if (idx == 0) begin
            m_addr = wr_addr; m_we = wr_be; m_din = wr_data;
            for (int b = 0; b < 4; b++) if (wr_be[b]) shadow[wr_addr][b*8 +: 8] = wr_data[b*8 +: 8];
         end else if (idx == 1) begin
            m_addr = tx_addr; m_din = 32'h0; m_rd_val = shadow[tx_addr];
         end else begin
            m_addr = pc_addr; m_din = 32'h0; m_rd_val = shadow[pc_addr];
         end
      end
      @(posedge clk); #1;
      check_eq("gnt",    {29'h0, pc_gnt, tx_gnt, wr_gnt}, {29'h0, m_gnt});
      check_eq("en",     {31'h0, bram_en}, {31'h0, m_en});
      check_eq("we",     {28'h0, bram_we}, {28'h0, m_we});
      check_eq("addr",   {23'h0, bram_addr}, {23'h0, m_addr});
      check_eq("din",    bram_din, m_din);
      check_eq("rvalid", {30'h0, pc_rvalid, tx_rvalid}, {30'h0, m_rv});
      if (m_rv != 2'b00) check_eq("rdata", bram_dout, m_rv_val);
   endtask

   task automatic do_reset();
      @(negedge clk); rst = 1'b0; model_reset();
      @(negedge clk); rst = 1'b1;
      @(posedge clk); #1;
   endtask

   function automatic logic [8:0] rand_addr();
      return ($urandom % 4 == 0) ? 9'h1FF : 9'($urandom % 16);
   endfunction

   initial begin
      rst = 1'b0;
      wr_req = 1'b0; tx_req = 1'b0; pc_req = 1'b0;
      wr_addr = 9'h0; tx_addr = 9'h0; pc_addr = 9'h0; wr_data = 32'h0; wr_be = 4'h0;
      bram_dout = 32'h0;
      for (int i = 0; i < 512; i++) begin ram[i] = 32'h0; shadow[i] = 32'h0; end
      model_reset();
      #22;
      check_eq("rst_gnt", {29'h0, pc_gnt, tx_gnt, wr_gnt}, 32'h0);
      check_eq("rst_en_busy", {30'h0, bram_en, busy}, 32'h0);
      check_eq("rst_addr_din", {23'h0, bram_addr} | bram_din, 32'h0);
      @(negedge clk); rst = 1'b1;
      @(posedge clk); #1;

      // Write then read back one word.
      wr_req = 1'b1; wr_addr = 9'h005; wr_data = 32'hDEADBEEF; wr_be = 4'hF;
      step();
      check_eq("t1_wr_gnt", {31'h0, wr_gnt}, 32'h1);
      check_eq("t1_we", {28'h0, bram_we}, 32'hF);
      check_eq("t1_addr", {23'h0, bram_addr}, 32'h005);
      wr_req = 1'b0; tx_req = 1'b1; tx_addr = 9'h005;
      step();
      check_eq("t1_tx_gnt", {31'h0, tx_gnt}, 32'h1);
      tx_req = 1'b0;
      step();
      check_eq("t1_tx_rvalid", {31'h0, tx_rvalid}, 32'h1);
      check_eq("t1_rdata", bram_dout, 32'hDEADBEEF);
      step(); step();

      // All three requesters held continuously.
`ifdef BRAM_ARB_RR_EN
      do_reset();
      wr_req = 1'b1; tx_req = 1'b1; pc_req = 1'b1; wr_addr = 9'h010; tx_addr = 9'h011; pc_addr = 9'h012;
      for (int j = 0; j < 6; j++) begin
         step();
         check_eq("rr_order", {29'h0, pc_gnt, tx_gnt, wr_gnt}, 32'(3'b001 << (j % 3)));
         check_eq("rr_en", {31'h0, bram_en}, 32'h1);
      end
`else
      wr_req = 1'b1; tx_req = 1'b1; pc_req = 1'b1; wr_addr = 9'h010; tx_addr = 9'h011; pc_addr = 9'h012;
      for (int j = 0; j < 20; j++) begin
         step();
         check_eq("fp_order", {29'h0, pc_gnt, tx_gnt, wr_gnt}, (j % 2 == 0) ? 32'h1 : 32'h2);
      end
`endif
      wr_req = 1'b0; tx_req = 1'b0; pc_req = 1'b0;
      step(); step(); step();

      // Lone perceptron holding its request.
      pc_req = 1'b1; pc_addr = 9'h003;
      for (int j = 0; j < 6; j++) begin
         step();
         check_eq("pc_alone_gnt", {31'h0, pc_gnt}, (j % 2 == 0) ? 32'h1 : 32'h0);
         check_eq("pc_alone_rv", {31'h0, pc_rvalid}, (j % 2 == 1) ? 32'h1 : 32'h0);
      end
      pc_req = 1'b0;
      step(); step();

      // Partial-byte write at the top address.
      wr_req = 1'b1; wr_addr = 9'h1FF; wr_data = 32'hFFFFFFFF; wr_be = 4'hF;
      step();
      wr_data = 32'h1234ABCD; wr_be = 4'b0011;
      step(); step();
      check_eq("t5_we", {28'h0, bram_we}, 32'h3);
      check_eq("t5_addr", {23'h0, bram_addr}, 32'h1FF);
      wr_req = 1'b0; tx_req = 1'b1; tx_addr = 9'h1FF;
      step();
      tx_req = 1'b0;
      step();
      check_eq("t5_rdata", bram_dout, 32'hFFFFABCD);
      step();

      // Reset while a read is in flight.
      tx_req = 1'b1; tx_addr = 9'h005;
      step();
      check_eq("t6_tx_gnt", {31'h0, tx_gnt}, 32'h1);
      tx_req = 1'b0;
      #4; rst = 1'b0; #1;
      check_eq("t6_rst_outs", {24'h0, pc_gnt, tx_gnt, wr_gnt, tx_rvalid, pc_rvalid, bram_en, busy, 1'b0}, 32'h0);
      check_eq("t6_rst_bus", {23'h0, bram_addr} | bram_din | {28'h0, bram_we}, 32'h0);
      for (int j = 0; j < 2; j++) begin
         @(posedge clk); #1;
         check_eq("t6_no_rv", {31'h0, tx_rvalid}, 32'h0);
      end
      @(negedge clk); rst = 1'b1; model_reset();
      @(posedge clk); #1;
      check_eq("t6_no_rv_post", {31'h0, tx_rvalid}, 32'h0);
      wr_req = 1'b1; tx_req = 1'b1; pc_req = 1'b1; wr_addr = 9'h020; wr_data = 32'h0BADF00D; wr_be = 4'hF;
      step();
      check_eq("t6_wr_first", {29'h0, pc_gnt, tx_gnt, wr_gnt}, 32'h1);
      wr_req = 1'b0; tx_req = 1'b0; pc_req = 1'b0;
      step(); step(); step();

      // Randomized traffic obeying the requester contract.
      for (int n = 0; n < 400; n++) begin
         step();
         if (m_gnt[0]) begin
            if ($urandom % 2 == 0) wr_req = 1'b0;
            else begin wr_addr = rand_addr(); wr_data = $urandom; wr_be = 4'($urandom); end
         end else if (!wr_req && $urandom % 3 == 0) begin
            wr_req = 1'b1; wr_addr = rand_addr(); wr_data = $urandom; wr_be = 4'($urandom);
         end
         if (m_gnt[1]) begin
            if ($urandom % 2 == 0) tx_req = 1'b0; else tx_addr = rand_addr();
         end else if (!tx_req && $urandom % 3 == 0) begin
            tx_req = 1'b1; tx_addr = rand_addr();
         end
         if (m_gnt[2]) begin
            if ($urandom % 2 == 0) pc_req = 1'b0; else pc_addr = rand_addr();
         end else if (!pc_req && $urandom % 3 == 0) begin
            pc_req = 1'b1; pc_addr = rand_addr();
         end
      end
      wr_req = 1'b0; tx_req = 1'b0; pc_req = 1'b0;
      for (int n = 0; n < 4; n++) step();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
